// File: rtl/wrbuf_pkg.sv
// wrbuf_pkg: shared types and constants for the Avalon posted write buffer.
package wrbuf_pkg;

  localparam int MAX_WR_LEN = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] data;
  } wrbuf_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_ACK   = 2'd2
  } wrbuf_state_t;

endpackage

// File: rtl/wrbuf_hazard_cmp.sv
// wrbuf_hazard_cmp: dword-span overlap test between one queued write and a
// pending read. Only exists when AVALON_WRBUF_HAZARD_EN is defined; the
// default build stalls reads on any queued write and needs no comparator.
`ifdef AVALON_WRBUF_HAZARD_EN
module wrbuf_hazard_cmp (
  input  logic        valid,
  input  logic [31:0] entry_addr,
  input  logic [2:0]  entry_len,
  input  logic [31:0] rd_addr,
  input  logic [3:0]  rd_len,
  output logic        hit
);

  logic [31:0] entry_last;
  logic [31:0] rd_last;

  assign entry_last = entry_addr + {29'd0, entry_len} - 32'd1;
  assign rd_last    = rd_addr + {28'd0, rd_len} - 32'd1;

  // Spans overlap when each one starts no later than the other one ends.
  always_comb begin
    hit = valid
       && (entry_addr[31:2] <= rd_last[31:2])
       && (rd_addr[31:2] <= entry_last[31:2]);
  end

  logic unused_low_bits;
  assign unused_low_bits = ^{entry_addr[1:0], entry_last[1:0], rd_addr[1:0], rd_last[1:0]};

endmodule
`endif

// File: rtl/avalon_wrbuf.sv
// avalon_wrbuf: posted write buffer ahead of the Avalon master's writeburst
// port, with in-order drain, flush handshake and read-after-write hazard flag.
// Build macro AVALON_WRBUF_HAZARD_EN: precise per-entry hazard compare;
// when undefined, any queued write makes read_hazard high.
module avalon_wrbuf
  import wrbuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [31:0]      wr_address,
  input  logic [2:0]       wr_length,
  input  logic [31:0]      wr_data,
  output logic             wr_ready,
  output logic             writeburst_do,
  output logic [31:0]      writeburst_address,
  output logic [2:0]       writeburst_length,
  output logic [31:0]      writeburst_data,
  input  logic             writeburst_done,
  input  logic [31:0]      rd_check_address,
  input  logic [3:0]       rd_check_length,
  output logic             read_hazard,
  input  logic             flush_req,
  output logic             flush_ack,
  output logic             wr_error,
  output logic [CNT_W-1:0] wr_count
);

  localparam int PTR_W = $clog2(DEPTH);

  wrbuf_entry_t     mem [DEPTH];
  wrbuf_entry_t     head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  wrbuf_state_t     state;
  wrbuf_state_t     state_nxt;
  logic             len_ok;
  logic             push;
  logic             store;
  logic             pop;

  // An accepted push with an illegal length is consumed but never stored.
  assign len_ok = (wr_length != 3'd0) && (wr_length <= 3'(MAX_WR_LEN));
  assign push   = wr_req && wr_ready;
  assign store  = push && len_ok;
  assign pop    = writeburst_done && (count != '0);

  assign wr_ready      = (state == ST_RUN) && (count != CNT_W'(DEPTH));
  assign flush_ack     = (state == ST_ACK);
  assign wr_count      = count;
  assign head          = mem[rd_ptr];
  assign writeburst_do = (count != '0);
  assign writeburst_address = head.addr;
  assign writeburst_length  = head.len;
  assign writeburst_data    = head.data;

  // Entry storage is left unreset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= '{addr: wr_address, len: wr_length, data: wr_data};
    end
  end

  // Pointers, occupancy, sticky length error and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_error <= 1'b0;
      state    <= ST_RUN;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(store) - CNT_W'(pop);
      if (push && !len_ok) wr_error <= 1'b1;
      state <= state_nxt;
    end
  end

  // Flush sequencing: stop accepting, wait for empty, pulse ack once.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush_req) state_nxt = ST_FLUSH;
      ST_FLUSH: if (count == '0) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

`ifdef AVALON_WRBUF_HAZARD_EN
  logic [DEPTH-1:0] hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PTR_W-1:0] offs;
    logic             valid;
    assign offs  = PTR_W'(i) - rd_ptr;
    assign valid = (CNT_W'(offs) < count);
    wrbuf_hazard_cmp u_cmp (
      .valid      (valid),
      .entry_addr (mem[i].addr),
      .entry_len  (mem[i].len),
      .rd_addr    (rd_check_address),
      .rd_len     (rd_check_length),
      .hit        (hit[i])
    );
  end

  assign read_hazard = |hit;
`else
  logic unused_rd_check;
  assign unused_rd_check = ^{rd_check_address, rd_check_length};
  assign read_hazard     = (count != '0);
`endif

endmodule

// File: tb/tb_avalon_wrbuf.sv
// tb_avalon_wrbuf: randomized self-checking bench for avalon_wrbuf against a
// queue-based reference model of the buffer contents.
module tb_avalon_wrbuf;
  import wrbuf_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_req;
  logic [31:0]      wr_address;
  logic [2:0]       wr_length;
  logic [31:0]      wr_data;
  logic             wr_ready;
  logic             writeburst_do;
  logic [31:0]      writeburst_address;
  logic [2:0]       writeburst_length;
  logic [31:0]      writeburst_data;
  logic             writeburst_done;
  logic [31:0]      rd_check_address;
  logic [3:0]       rd_check_length;
  logic             read_hazard;
  logic             flush_req;
  logic             flush_ack;
  logic             wr_error;
  logic [CNT_W-1:0] wr_count;

  int n_cmp  = 0;
  int n_fail = 0;

  wrbuf_entry_t q[$];
  bit           err_m;

  always #5 clk = ~clk;

  avalon_wrbuf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_address(wr_address), .wr_length(wr_length), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .writeburst_do(writeburst_do), .writeburst_address(writeburst_address),
    .writeburst_length(writeburst_length), .writeburst_data(writeburst_data),
    .writeburst_done(writeburst_done),
    .rd_check_address(rd_check_address), .rd_check_length(rd_check_length),
    .read_hazard(read_hazard),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .wr_error(wr_error), .wr_count(wr_count)
  );

  // Reference hazard rule: dword spans of queued writes vs the read span.
  function automatic bit exp_hazard(input logic [31:0] ra, input logic [3:0] rl);
    bit h = 1'b0;
`ifdef AVALON_WRBUF_HAZARD_EN
    logic [31:0] rs, re, es, ee;
    rs = ra >> 2;
    re = (ra + 32'(rl) - 32'd1) >> 2;
    foreach (q[i]) begin
      es = q[i].addr >> 2;
      ee = (q[i].addr + 32'(q[i].len) - 32'd1) >> 2;
      if (es <= re && rs <= ee) h = 1'b1;
    end
`else
    h = (q.size() != 0);
`endif
    return h;
  endfunction

  task automatic drive_idle();
    wr_req = 1'b0; wr_address = '0; wr_length = 3'd0; wr_data = '0;
    writeburst_done = 1'b0; flush_req = 1'b0;
    rd_check_address = '0; rd_check_length = 4'd1;
  endtask

  task automatic drive_push(input logic [31:0] a, input logic [2:0] l, input logic [31:0] d);
    wr_req = 1'b1; wr_address = a; wr_length = l; wr_data = d;
  endtask

  // Apply the buffer rules to the model for the inputs now driven, then clock.
  task automatic advance();
    bit accept, popm;
    accept = wr_req && !flush_req && (q.size() < DEPTH);
    popm   = writeburst_done && (q.size() != 0);
    if (popm) void'(q.pop_front());
    if (accept) begin
      if (wr_length >= 3'd1 && wr_length <= 3'd4)
        q.push_back('{addr: wr_address, len: wr_length, data: wr_data});
      else
        err_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete(); err_m = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (writeburst_do !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_do got %b want 0", writeburst_do); end
    n_cmp++; if (wr_count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", wr_count); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 1", wr_ready); end
    n_cmp++; if (flush_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ack got %b want 0", flush_ack); end
    n_cmp++; if (wr_error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got %b want 0", wr_error); end
    n_cmp++; if (read_hazard !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hazard got %b want 0", read_hazard); end
  endtask

  task automatic test_single();
    drive_push(32'h0000_1000, 3'd4, 32'hDEAD_BEEF);
    advance();
    drive_idle();
    #1;
    n_cmp++; if (writeburst_do !== 1'b1) begin n_fail++; $display("[TB] FAIL single_do got %b want 1", writeburst_do); end
    n_cmp++; if (writeburst_address !== 32'h0000_1000) begin n_fail++; $display("[TB] FAIL single_addr got %h want 00001000", writeburst_address); end
    n_cmp++; if (writeburst_length !== 3'd4) begin n_fail++; $display("[TB] FAIL single_len got %0d want 4", writeburst_length); end
    n_cmp++; if (writeburst_data !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL single_data got %h want deadbeef", writeburst_data); end
    writeburst_done = 1'b1;
    advance();
    drive_idle();
    #1;
    n_cmp++; if (wr_count !== 3'd0) begin n_fail++; $display("[TB] FAIL single_count got %0d want 0", wr_count); end
    n_cmp++; if (writeburst_do !== 1'b0) begin n_fail++; $display("[TB] FAIL single_do_after got %b want 0", writeburst_do); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive_push($urandom, 3'($urandom_range(1, 4)), $urandom);
      advance();
    end
    drive_push(32'hBAD0_0000, 3'd4, 32'h5555_AAAA);
    #1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready got %b want 0", wr_ready); end
    advance();
    drive_idle();
    #1;
    n_cmp++; if (wr_count !== CNT_W'(q.size())) begin n_fail++; $display("[TB] FAIL full_count got %0d want %0d", wr_count, q.size()); end
    writeburst_done = 1'b1;
    while (q.size() != 0) begin
      #1;
      n_cmp++; if (writeburst_address !== q[0].addr || writeburst_data !== q[0].data || writeburst_length !== q[0].len) begin
        n_fail++; $display("[TB] FAIL full_drain got %h/%0d/%h want %h/%0d/%h", writeburst_address, writeburst_length,
                           writeburst_data, q[0].addr, q[0].len, q[0].data);
      end
      advance();
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive_push($urandom, 3'($urandom_range(1, 4)), $urandom);
      advance();
    end
    drive_push($urandom, 3'($urandom_range(1, 4)), $urandom);
    writeburst_done = 1'b1;
    advance();
    drive_idle();
    #1;
    n_cmp++; if (wr_count !== 3'd2) begin n_fail++; $display("[TB] FAIL b2b_count got %0d want 2", wr_count); end
    n_cmp++; if (writeburst_address !== q[0].addr) begin n_fail++; $display("[TB] FAIL b2b_head got %h want %h", writeburst_address, q[0].addr); end
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 3) != 0) drive_push($urandom, 3'($urandom_range(1, 4)), $urandom);
      else wr_req = 1'b0;
      writeburst_done  = ($urandom_range(0, 2) != 0);
      rd_check_address = $urandom;
      rd_check_length  = 4'($urandom_range(1, 8));
      #1;
      n_cmp++; if (wr_count !== CNT_W'(q.size()) || wr_ready !== (q.size() < DEPTH) || writeburst_do !== (q.size() != 0)) begin
        n_fail++; $display("[TB] FAIL rand_state c=%0d got cnt=%0d rdy=%b do=%b want cnt=%0d", c, wr_count, wr_ready, writeburst_do, q.size());
      end
      if (q.size() != 0) begin
        n_cmp++; if (writeburst_address !== q[0].addr || writeburst_data !== q[0].data || writeburst_length !== q[0].len) begin
          n_fail++; $display("[TB] FAIL rand_head c=%0d got %h/%0d/%h want %h/%0d/%h", c, writeburst_address, writeburst_length,
                             writeburst_data, q[0].addr, q[0].len, q[0].data);
        end
      end
      n_cmp++; if (read_hazard !== exp_hazard(rd_check_address, rd_check_length) || wr_error !== err_m) begin
        n_fail++; $display("[TB] FAIL rand_flags c=%0d got hz=%b err=%b want hz=%b err=%b", c, read_hazard, wr_error,
                           exp_hazard(rd_check_address, rd_check_length), err_m);
      end
      advance();
    end
    drive_idle();
    writeburst_done = 1'b1;
    repeat (DEPTH + 1) advance();
    drive_idle();
  endtask

  task automatic test_hazard();
    bit want;
    drive_push(32'h0000_2003, 3'd2, $urandom);
    advance();
    drive_idle();
    rd_check_address = 32'h0000_2004; rd_check_length = 4'd1;
    #1;
    n_cmp++; if (read_hazard !== 1'b1) begin n_fail++; $display("[TB] FAIL hz_overlap got %b want 1", read_hazard); end
    rd_check_address = 32'h0000_3000; rd_check_length = 4'd4;
    want = exp_hazard(rd_check_address, rd_check_length);
    #1;
    n_cmp++; if (read_hazard !== want) begin n_fail++; $display("[TB] FAIL hz_far got %b want %b", read_hazard, want); end
    for (int i = 0; i < 24; i++) begin
      rd_check_address = 32'h0000_1FF0 + 32'($urandom_range(0, 40));
      rd_check_length  = 4'($urandom_range(1, 8));
      want = exp_hazard(rd_check_address, rd_check_length);
      #1;
      n_cmp++; if (read_hazard !== want) begin
        n_fail++; $display("[TB] FAIL hz_rand a=%h l=%0d got %b want %b", rd_check_address, rd_check_length, read_hazard, want);
      end
    end
    writeburst_done = 1'b1;
    advance();
    drive_idle();
  endtask

  task automatic test_flush();
    int zero_at;
    bit want_ack;
    bit want_rdy;
    for (int i = 0; i < 3; i++) begin
      drive_push($urandom, 3'($urandom_range(1, 4)), $urandom);
      advance();
    end
    drive_idle();
    zero_at = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (zero_at < 0 && q.size() == 0) zero_at = cyc;
      want_ack = (zero_at >= 0) && (cyc == zero_at + 1);
      want_rdy = (cyc == 0) || (zero_at >= 0 && cyc == zero_at + 2);
      flush_req = !(zero_at >= 0 && cyc >= zero_at + 1);
      writeburst_done = cyc[0];
      #1;
      n_cmp++; if (flush_ack !== want_ack || wr_ready !== want_rdy) begin
        n_fail++; $display("[TB] FAIL flush c=%0d got ack=%b rdy=%b want ack=%b rdy=%b", cyc, flush_ack, wr_ready, want_ack, want_rdy);
      end
      if (zero_at >= 0 && cyc == zero_at + 2) break;
      advance();
    end
    drive_idle();
    for (int cyc = 0; cyc < 4; cyc++) begin
      flush_req = (cyc < 2);
      #1;
      n_cmp++; if (flush_ack !== (cyc == 2)) begin
        n_fail++; $display("[TB] FAIL flush_empty c=%0d got %b want %b", cyc, flush_ack, (cyc == 2));
      end
      advance();
    end
    drive_idle();
  endtask

  task automatic test_error();
    drive_push(32'h0000_4000, 3'd0, $urandom);
    advance();
    drive_idle();
    #1;
    n_cmp++; if (wr_count !== 3'd0 || wr_error !== 1'b1) begin
      n_fail++; $display("[TB] FAIL err_len0 got cnt=%0d err=%b want cnt=0 err=1", wr_count, wr_error);
    end
    for (int i = 0; i < 3; i++) begin
      drive_push($urandom, (i == 1) ? 3'd6 : 3'd3, $urandom);
      advance();
    end
    drive_idle();
    #1;
    n_cmp++; if (wr_count !== CNT_W'(q.size()) || wr_error !== err_m) begin
      n_fail++; $display("[TB] FAIL err_sticky got cnt=%0d err=%b want cnt=%0d err=%b", wr_count, wr_error, q.size(), err_m);
    end
    writeburst_done = 1'b1;
    advance();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (writeburst_do !== 1'b0 || wr_count !== 3'd0 || wr_error !== 1'b0) begin
      n_fail++; $display("[TB] FAIL async_reset got do=%b cnt=%0d err=%b want 0/0/0", writeburst_do, wr_count, wr_error);
    end
    drive_idle();
    q.delete(); err_m = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    advance();
    n_cmp++; if (writeburst_do !== 1'b0 || wr_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL post_reset got do=%b rdy=%b want 0/1", writeburst_do, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
